// File: rtl/pwm_audio_pkg.sv
// Shared types and constants for the PWM audio output path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: env_state_t envelope states, MIDSCALE silence level, FRAME_LEN
// PWM frame length in clocks, and sat_inc8 saturating increment.
package pwm_audio_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    PLAY      = 2'd2,
    RAMP_DOWN = 2'd3
  } env_state_t;

  localparam logic [7:0] MIDSCALE  = 8'd128;
  localparam int         FRAME_LEN = 256;
  localparam logic [7:0] CNT_LAST  = 8'(FRAME_LEN - 1);

  // Add one without wrapping past full scale.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    logic [7:0] r;
    r = v;
    if (inc && (v != 8'hFF)) begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_audio_out_if.sv
// Bundle of the mixer-side inputs and the PWM-side outputs of pwm_audio_out.
// Latency: n/a (wires only).
// Backpressure: none; sample_valid is a one-cycle strobe that is always accepted.
// Ports (master drives): enable, sample[7:0], sample_valid, volume[VOL_W-1:0]
// Ports (slave drives):  pwm_out, frame_start, active
interface pwm_audio_out_if #(
  parameter int VOL_W = 4
);
  logic             enable;
  logic [7:0]       sample;
  logic             sample_valid;
  logic [VOL_W-1:0] volume;
  logic             pwm_out;
  logic             frame_start;
  logic             active;

  modport master (
    output enable, sample, sample_valid, volume,
    input  pwm_out, frame_start, active
  );

  modport slave (
    input  enable, sample, sample_valid, volume,
    output pwm_out, frame_start, active
  );
endinterface

// File: rtl/pwm_envelope.sv
// Fade-in/fade-out envelope: state machine plus level env, advanced only at frame edges.
// Latency: state/env change on the clock edge where frame_edge is high.
// Backpressure: none; enable is level-sensitive and only looked at on frame edges.
// Ports: clk, rst (async active-high), frame_edge (cnt==last), enable,
//        env[VOL_W-1:0] current level, state current envelope state.
module pwm_envelope
  import pwm_audio_pkg::*;
#(
  parameter int RAMP_SHIFT = 4,
  parameter int VOL_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_edge,
  input  logic             enable,
  output logic [VOL_W-1:0] env,
  output env_state_t       state
);

  // A zero RAMP_SHIFT still needs a one-bit step register; with STEP_LAST=0
  // it wraps on every frame.
  localparam int               STEP_W    = (RAMP_SHIFT > 0) ? RAMP_SHIFT : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'((1 << RAMP_SHIFT) - 1);
  localparam logic [VOL_W-1:0]  ENV_MAX   = '1;
  localparam logic [VOL_W-1:0]  ENV_ZERO  = '0;

  env_state_t        state_q, state_d;
  logic [VOL_W-1:0]  env_q, env_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              step_wrap;
  logic [STEP_W-1:0] step_inc;

  always_comb begin
    state_d   = state_q;
    env_d     = env_q;
    step_d    = step_q;
    step_wrap = (step_q == STEP_LAST);
    step_inc  = step_wrap ? '0 : step_q + 1'b1;

    if (frame_edge) begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_d = RAMP_UP;
            env_d   = ENV_ZERO;
            step_d  = '0;
          end
        end

        RAMP_UP: begin
          if (!enable) begin
            // Fade out from wherever the fade-in had got to.
            state_d = RAMP_DOWN;
            step_d  = '0;
          end else if (env_q == ENV_MAX) begin
            // Re-enabled at full level during a fade-out.
            state_d = PLAY;
          end else begin
            step_d = step_inc;
            if (step_wrap) begin
              env_d = env_q + 1'b1;
              if (env_q == ENV_MAX - 1'b1) begin
                state_d = PLAY;
              end
            end
          end
        end

        PLAY: begin
          if (!enable) begin
            state_d = RAMP_DOWN;
            step_d  = '0;
          end
        end

        RAMP_DOWN: begin
          if (enable) begin
            // Fade back in from the current level; never passes through IDLE.
            state_d = RAMP_UP;
            step_d  = '0;
          end else if (env_q == ENV_ZERO) begin
            state_d = IDLE;
          end else begin
            step_d = step_inc;
            if (step_wrap) begin
              env_d = env_q - 1'b1;
              if (env_q == ENV_ZERO + 1'b1) begin
                state_d = IDLE;
              end
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      env_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      step_q  <= step_d;
    end
  end

  assign env   = env_q;
  assign state = state_q;

endmodule

// File: rtl/pwm_audio_out.sv
// 8-bit sample to 1-bit PWM pin, scaled by min(volume, envelope), frame = 256 clk.
// Latency: sample held 1 cycle after strobe, applied at the next frame edge; pwm_out lags cnt by 1.
// Backpressure: none; every sample_valid strobe overwrites the held sample.
// Ports: clk, rst (async active-high), bus (pwm_audio_out_if.slave):
//   in enable, sample[7:0], sample_valid, volume[VOL_W-1:0]; out pwm_out, frame_start, active.
// Build option: define PWM_NOISE_SHAPE_EN for first-order noise shaping of the truncated bits.
module pwm_audio_out
  import pwm_audio_pkg::*;
#(
  parameter int RAMP_SHIFT = 4,
  parameter int VOL_W      = 4
) (
  input  logic           clk,
  input  logic           rst,
  pwm_audio_out_if.slave bus
);

  // centered (9b signed) * eff (VOL_W unsigned + sign) needs 9+VOL_W+1 bits.
  localparam int P_W = 9 + VOL_W + 1;

  logic [7:0]             cnt_q, cnt_d;
  logic [7:0]             held_q, held_d;
  logic [7:0]             duty_q, duty_d;
  logic                   pwm_out_q, pwm_out_d;
  logic                   frame_start_q, frame_start_d;
  logic                   frame_edge;

  logic [VOL_W-1:0]       env;
  env_state_t             state;
  logic [VOL_W-1:0]       eff;
  logic signed [8:0]      centered;
  logic signed [P_W-1:0]  product;
  logic [7:0]             duty_base;
  logic [7:0]             duty_next;

  pwm_envelope #(
    .RAMP_SHIFT (RAMP_SHIFT),
    .VOL_W      (VOL_W)
  ) u_envelope (
    .clk        (clk),
    .rst        (rst),
    .frame_edge (frame_edge),
    .enable     (bus.enable),
    .env        (env),
    .state      (state)
  );

  assign frame_edge = (cnt_q == CNT_LAST);

  // Scaling. The scaled offset always lies within -120..+119, so only the
  // low 8 bits above the truncated fraction are needed and modulo-256
  // addition to MIDSCALE gives the exact duty.
  always_comb begin
    eff       = (env < bus.volume) ? env : bus.volume;
    centered  = $signed({1'b0, held_q}) - $signed({1'b0, MIDSCALE});
    product   = P_W'(centered) * $signed({{(P_W - VOL_W){1'b0}}, eff});
    duty_base = MIDSCALE + product[VOL_W+7:VOL_W];
  end

`ifdef PWM_NOISE_SHAPE_EN
  // The truncated fraction is accumulated once per frame; each carry out
  // adds one extra high cycle, so the long-run average keeps the fraction.
  logic [VOL_W-1:0]       err_q, err_d;
  logic [VOL_W:0]         err_sum;
  logic [P_W-VOL_W-9:0]   unused_hi;

  always_comb begin
    err_sum   = {1'b0, err_q} + {1'b0, product[VOL_W-1:0]};
    duty_next = sat_inc8(duty_base, err_sum[VOL_W]);
    err_d     = err_q;
    if (state == IDLE) begin
      err_d = '0;
    end else if (frame_edge) begin
      err_d = err_sum[VOL_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign unused_hi = product[P_W-1:VOL_W+8];
`else
  logic [P_W-VOL_W-9:0]   unused_hi;
  logic [VOL_W-1:0]       unused_frac;

  assign duty_next   = duty_base;
  assign unused_hi   = product[P_W-1:VOL_W+8];
  assign unused_frac = product[VOL_W-1:0];
`endif

  always_comb begin
    cnt_d         = cnt_q + 8'd1;
    // A strobe in the cnt=255 cycle lands in held_q on the same edge that
    // loads duty, so that duty still uses the previous held value.
    held_d        = bus.sample_valid ? bus.sample : held_q;
    duty_d        = frame_edge ? duty_next : duty_q;
    pwm_out_d     = (state != IDLE) && (cnt_q < duty_q);
    frame_start_d = (cnt_q == 8'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= 8'd0;
      held_q        <= MIDSCALE;
      duty_q        <= MIDSCALE;
      pwm_out_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      held_q        <= held_d;
      duty_q        <= duty_d;
      pwm_out_q     <= pwm_out_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.pwm_out     = pwm_out_q;
  assign bus.frame_start = frame_start_q;
  assign bus.active      = (state != IDLE);

endmodule

// File: tb/tb_pwm_audio_out.sv
// Self-checking bench for pwm_audio_out: frame-level reference model feeds a
// scoreboard of expected high-cycle counts and active flags per PWM frame.
// Runs with RAMP_SHIFT=0 so the envelope moves one step per frame.
module tb_pwm_audio_out;

  localparam int RS      = 0;
  localparam int VW      = 4;
  localparam int ENV_TOP = (1 << VW) - 1;
  localparam int STEPS   = 1 << RS;
  localparam int SCALE   = 1 << VW;

  localparam int S_IDLE = 0;
  localparam int S_UP   = 1;
  localparam int S_PLAY = 2;
  localparam int S_DOWN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_audio_out_if #(.VOL_W(VW)) bus ();

  pwm_audio_out #(
    .RAMP_SHIFT (RS),
    .VOL_W      (VW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_frames = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (one update per PWM frame) -------------
  typedef struct {
    int highs;
    int act;
  } exp_t;

  exp_t exp_q[$];

  int m_cnt, m_held, m_env, m_step, m_state, m_err;

  function automatic int floor_div(input int p);
    if (p >= 0) return p / SCALE;
    return -((-p + SCALE - 1) / SCALE);
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_held  = 128;
    m_env   = 0;
    m_step  = 0;
    m_state = S_IDLE;
    m_err   = 0;
    exp_q.delete();
    exp_q.push_back('{highs: 0, act: 0});
  endtask

  task automatic model_frame(input int en, input int vol);
    int eff, p, duty;
    eff  = (m_env < vol) ? m_env : vol;
    p    = (m_held - 128) * eff;
    duty = 128 + floor_div(p);
`ifdef PWM_NOISE_SHAPE_EN
    if (m_state == S_IDLE) m_err = 0;
    else begin
      m_err += p - floor_div(p) * SCALE;
      if (m_err >= SCALE) begin
        m_err -= SCALE;
        duty = (duty < 255) ? duty + 1 : 255;
      end
    end
`endif
    case (m_state)
      S_IDLE: if (en != 0) begin m_state = S_UP; m_env = 0; m_step = 0; end
      S_UP: begin
        if (en == 0) begin m_state = S_DOWN; m_step = 0; end
        else if (m_env == ENV_TOP) m_state = S_PLAY;
        else begin
          m_step = (m_step + 1) % STEPS;
          if (m_step == 0) begin
            m_env++;
            if (m_env == ENV_TOP) m_state = S_PLAY;
          end
        end
      end
      S_PLAY: if (en == 0) begin m_state = S_DOWN; m_step = 0; end
      default: begin
        if (en != 0) begin m_state = S_UP; m_step = 0; end
        else if (m_env == 0) m_state = S_IDLE;
        else begin
          m_step = (m_step + 1) % STEPS;
          if (m_step == 0) begin
            m_env--;
            if (m_env == 0) m_state = S_IDLE;
          end
        end
      end
    endcase
    exp_q.push_back('{highs: (m_state != S_IDLE) ? duty : 0,
                      act:   (m_state != S_IDLE) ? 1 : 0});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        if (m_cnt == 255) model_frame(int'(bus.enable), int'(bus.volume));
        if (bus.sample_valid) m_held = int'(bus.sample);
        m_cnt = (m_cnt + 1) % 256;
      end
    end
  end

  // ---------------- monitor: one comparison set per completed frame --------
  initial begin
    int   highs = 0;
    int   ncyc  = 0;
    bit   in_frame = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        in_frame = 1'b0;
        continue;
      end
      if (bus.frame_start) begin
        if (in_frame) begin
          check("frame_len", ncyc, 256);
          check("sb_nonempty", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_highs", highs, e.highs);
            n_frames++;
          end
        end
        if (exp_q.size() > 0) check("frame_active", int'(bus.active), exp_q[0].act);
        in_frame = 1'b1;
        highs    = int'(bus.pwm_out);
        ncyc     = 1;
      end else if (in_frame) begin
        highs += int'(bus.pwm_out);
        ncyc++;
        if (ncyc > 256) begin
          check("frame_start_missing", ncyc, 256);
          in_frame = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic strobe(input int s);
    @(posedge clk); #1;
    bus.sample       = 8'(s);
    bus.sample_valid = 1'b1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic wait_frame_start(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.frame_start) begin
        found = 1'b1;
        break;
      end
    end
    check({"sync_", tag}, int'(found), 1);
  endtask

  // Call right after wait_frame_start: counts highs over the 256 pwm cycles.
  task automatic count_frame(output int h);
    h = int'(bus.pwm_out);
    repeat (255) begin
      @(negedge clk);
      h += int'(bus.pwm_out);
    end
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ------------------------------
  initial begin
    int h;
    bus.enable       = 1'b0;
    bus.sample       = 8'd128;
    bus.sample_valid = 1'b0;
    bus.volume       = 4'd15;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pwm_out", int'(bus.pwm_out), 0);
    check("rst_frame_start", int'(bus.frame_start), 0);
    check("rst_active", int'(bus.active), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("pre_first_frame_start", int'(bus.frame_start), 0);
    @(posedge clk); @(negedge clk);
    check("first_frame_start", int'(bus.frame_start), 1);

    // Fade-in to PLAY with sample 200, volume 15
    repeat (10) @(posedge clk);
    strobe(200);
    bus.enable = 1'b1;
    repeat (20 * 256) @(posedge clk);
    wait_frame_start("play");
    count_frame(h);
    check("play_duty_195", h, 195);
    check("play_active", int'(bus.active), 1);

    // Mid-frame sample update: current frame unchanged, next frame 247
    wait_frame_start("midframe");
    h = int'(bus.pwm_out);
    for (int i = 1; i < 256; i++) begin
      @(negedge clk);
      h += int'(bus.pwm_out);
      if (i == 99) begin
        bus.sample       = 8'd255;
        bus.sample_valid = 1'b1;
      end else if (i == 100) begin
        bus.sample_valid = 1'b0;
      end
    end
    check("midframe_old_duty", h, 195);
    @(negedge clk);
    check("midframe_next_start", int'(bus.frame_start), 1);
    count_frame(h);
    check("midframe_new_duty_247", h, 247);

    // Silence sample at a random nonzero volume
    bus.volume = 4'($urandom_range(1, 15));
    strobe(128);
    wait_frame_start("mid_a");
    wait_frame_start("mid_b");
    count_frame(h);
    check("midscale_128", h, 128);

    // Volume 0 with full-negative sample
    bus.volume = 4'd0;
    strobe(0);
    wait_frame_start("vol0_a");
    wait_frame_start("vol0_b");
    count_frame(h);
    check("vol0_duty_128", h, 128);

    // Fade abort: ramp part way down, re-enable, never reach IDLE
    bus.volume = 4'd15;
    strobe(200);
    bus.enable = 1'b0;
    for (int f = 0; f < 10; f++) begin
      wait_frame_start("fade_down");
      check("fade_down_active", int'(bus.active), 1);
    end
    bus.enable = 1'b1;
    for (int f = 0; f < 12; f++) begin
      wait_frame_start("fade_up");
      check("fade_up_active", int'(bus.active), 1);
    end

    // Asynchronous reset in the middle of a high phase
    wait_frame_start("rst_mid");
    repeat (50) @(negedge clk);
    check("pre_rst_pwm_high", int'(bus.pwm_out), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm_out", int'(bus.pwm_out), 0);
    check("async_rst_active", int'(bus.active), 0);
    check("async_rst_frame_start", int'(bus.frame_start), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("restart_frame_start", int'(bus.frame_start), 1);

    // Random phase: samples, volume and enable changing at arbitrary cycles
    for (int k = 0; k < 240; k++) begin
      repeat ($urandom_range(20, 90)) @(posedge clk);
      #1;
      case ($urandom_range(0, 7))
        0:       bus.enable = ~bus.enable;
        1:       bus.volume = 4'($urandom_range(0, 15));
        2:       bus.sample = 8'd0;
        3:       bus.sample = 8'd255;
        4:       bus.sample = 8'd128;
        default: bus.sample = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        bus.sample_valid = 1'b1;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
      end
    end
    repeat (600) @(posedge clk);

    check("frames_compared_enough", int'(n_frames >= 70), 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
